// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-I control/execute slice.
package mips_pkg;

   typedef enum logic [3:0] {
      ST_HALT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_EXEC1  = 4'd3,
      ST_EXEC2  = 4'd4
   } state_t;

   typedef enum logic [3:0] {
      ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ANDI, ALUOP_ORI, ALUOP_XORI,
      ALUOP_SLTI, ALUOP_SLTIU, ALUOP_BNE, ALUOP_BLEZ, ALUOP_BGTZ, ALUOP_REGIMM
   } aluop_t;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
      ALU_ANDZ, ALU_ORZ, ALU_XORZ,
      ALU_BNE, ALU_BLEZ, ALU_BGTZ, ALU_BLTZ, ALU_BGEZ
   } aluctrl_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/mips_alu_core.sv
// Pure combinational 32-bit ALU; branch ops return 0 exactly when the branch is taken.
module mips_alu_core
   import mips_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_shamt,
   input  aluctrl_t    i_ctrl,
   output logic [31:0] o_result,
   output logic        o_zero
);

   logic [31:0] w_zext;
   assign w_zext = {16'h0000, i_b[15:0]};

   always_comb begin
      o_result = i_a + i_b;
      case (i_ctrl)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_NOR:  o_result = ~(i_a | i_b);
         ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
         ALU_SLTU: o_result = {31'd0, i_a < i_b};
         ALU_SLL:  o_result = i_b << i_shamt;
         ALU_SRL:  o_result = i_b >> i_shamt;
         ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
         ALU_SLLV: o_result = i_b << i_a[4:0];
         ALU_SRLV: o_result = i_b >> i_a[4:0];
         ALU_SRAV: o_result = $signed(i_b) >>> i_a[4:0];
         ALU_ANDZ: o_result = i_a & w_zext;
         ALU_ORZ:  o_result = i_a | w_zext;
         ALU_XORZ: o_result = i_a ^ w_zext;
         // Inverted sense so that the zero flag doubles as "branch taken"
         ALU_BNE:  o_result = {31'd0, i_a == i_b};
         ALU_BLEZ: o_result = {31'd0, !($signed(i_a) <= 32'sd0)};
         ALU_BGTZ: o_result = {31'd0, !($signed(i_a) > 32'sd0)};
         ALU_BLTZ: o_result = {31'd0, !i_a[31]};
         ALU_BGEZ: o_result = {31'd0, i_a[31]};
         default:  o_result = i_a + i_b;
      endcase
   end

   assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_ctrl_exec.sv
// Sequencer, main decoder and ALU-control decoder for the multi-cycle MIPS-I bus CPU,
// wrapped around the combinational ALU core.
module mips_ctrl_exec
   import mips_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_waitrequest,
   input  logic        i_pc_zero,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [3:0]  o_state,
   output logic        o_active,
   output logic        o_memread,
   output logic        o_memwrite,
   output logic        o_pctoadd,
   output logic        o_inwrite,
   output logic        o_pcwrite,
   output logic        o_regwrite,
   output logic        o_ALUSrc,
   output logic        o_regdst,
   output logic        o_memtoreg,
   output logic        o_jump,
   output logic        o_branch,
   output logic        o_regtojump,
   output logic        o_link,
   output logic        o_loadimmed,
   output logic        o_hitoreg,
   output logic        o_lotoreg,
   output logic        o_div_mult_en,
   output logic        o_div_mult_signed,
   output logic [1:0]  o_div_mult_op,
   output logic [2:0]  o_ExtendOp,
   output logic [31:0] o_result,
   output logic        o_zero
);

   state_t     r_state;
   logic       r_active;
   logic [5:0] w_opcode;
   logic [4:0] w_rt;
   logic [4:0] w_shamt;
   logic [5:0] w_funct;
   logic       w_unusedBits;
   logic       w_decRegWrite;
   logic       w_decDivMult;
   logic       w_isLoad;
   logic       w_isStore;
   aluop_t     w_aluOp;
   aluctrl_t   w_aluCtrl;

   assign w_opcode     = i_instr[31:26];
   assign w_rt         = i_instr[20:16];
   assign w_shamt      = i_instr[10:6];
   assign w_funct      = i_instr[5:0];
   assign w_unusedBits = ^{i_instr[25:21], i_instr[15:11]};

   // A PC of zero halts the CPU from any running state, even during a bus stall
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_HALT;
         r_active <= 1'b0;
      end else if (i_pc_zero && (r_state != ST_HALT)) begin
         r_state  <= ST_HALT;
         r_active <= 1'b0;
      end else if (!i_waitrequest) begin
         case (r_state)
            ST_HALT: begin
               r_state  <= ST_FETCH;
               r_active <= 1'b1;
            end
            ST_FETCH:  r_state <= ST_DECODE;
            ST_DECODE: r_state <= ST_EXEC1;
            ST_EXEC1:  r_state <= ST_EXEC2;
            ST_EXEC2:  r_state <= ST_FETCH;
            default: begin
               r_state  <= ST_HALT;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign o_state  = r_state;
   assign o_active = r_active;

   always_comb begin
      o_ALUSrc          = 1'b0;
      o_regdst          = 1'b0;
      o_memtoreg        = 1'b0;
      o_jump            = 1'b0;
      o_branch          = 1'b0;
      o_regtojump       = 1'b0;
      o_link            = 1'b0;
      o_loadimmed       = 1'b0;
      o_hitoreg         = 1'b0;
      o_lotoreg         = 1'b0;
      o_div_mult_signed = 1'b0;
      o_div_mult_op     = 2'b00;
      o_ExtendOp        = 3'b000;
      w_decRegWrite     = 1'b0;
      w_decDivMult      = 1'b0;
      w_isLoad          = 1'b0;
      w_isStore         = 1'b0;
      w_aluOp           = ALUOP_ADD;
      case (w_opcode)
         OP_RTYPE: begin
            w_aluOp = ALUOP_RTYPE;
            case (w_funct)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                  o_regdst      = 1'b1;
                  w_decRegWrite = 1'b1;
               end
               FN_JR: begin
                  o_jump      = 1'b1;
                  o_regtojump = 1'b1;
               end
               FN_JALR: begin
                  o_jump        = 1'b1;
                  o_regtojump   = 1'b1;
                  o_link        = 1'b1;
                  o_regdst      = 1'b1;
                  w_decRegWrite = 1'b1;
               end
               FN_MFHI: begin
                  o_hitoreg     = 1'b1;
                  o_regdst      = 1'b1;
                  w_decRegWrite = 1'b1;
               end
               FN_MFLO: begin
                  o_lotoreg     = 1'b1;
                  o_regdst      = 1'b1;
                  w_decRegWrite = 1'b1;
               end
               FN_MULT: begin
                  w_decDivMult      = 1'b1;
                  o_div_mult_signed = 1'b1;
               end
               FN_MULTU: w_decDivMult = 1'b1;
               FN_DIV: begin
                  w_decDivMult      = 1'b1;
                  o_div_mult_signed = 1'b1;
                  o_div_mult_op     = 2'b01;
               end
               FN_DIVU: begin
                  w_decDivMult  = 1'b1;
                  o_div_mult_op = 2'b01;
               end
               FN_MTHI: begin
                  w_decDivMult  = 1'b1;
                  o_div_mult_op = 2'b10;
               end
               FN_MTLO: begin
                  w_decDivMult  = 1'b1;
                  o_div_mult_op = 2'b11;
               end
               default: ;
            endcase
         end
         OP_REGIMM: begin
            w_aluOp = ALUOP_REGIMM;
            case (w_rt)
               RT_BLTZ, RT_BGEZ: o_branch = 1'b1;
               RT_BLTZAL, RT_BGEZAL: begin
                  o_branch      = 1'b1;
                  o_link        = 1'b1;
                  w_decRegWrite = 1'b1;
               end
               default: ;
            endcase
         end
         OP_J: o_jump = 1'b1;
         OP_JAL: begin
            o_jump        = 1'b1;
            o_link        = 1'b1;
            w_decRegWrite = 1'b1;
         end
         OP_BEQ: begin
            o_branch = 1'b1;
            w_aluOp  = ALUOP_SUB;
         end
         OP_BNE: begin
            o_branch = 1'b1;
            w_aluOp  = ALUOP_BNE;
         end
         OP_BLEZ: begin
            o_branch = 1'b1;
            w_aluOp  = ALUOP_BLEZ;
         end
         OP_BGTZ: begin
            o_branch = 1'b1;
            w_aluOp  = ALUOP_BGTZ;
         end
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: begin
            o_ALUSrc      = 1'b1;
            w_decRegWrite = 1'b1;
            case (w_opcode)
               OP_ANDI:  w_aluOp = ALUOP_ANDI;
               OP_ORI:   w_aluOp = ALUOP_ORI;
               OP_XORI:  w_aluOp = ALUOP_XORI;
               OP_SLTI:  w_aluOp = ALUOP_SLTI;
               OP_SLTIU: w_aluOp = ALUOP_SLTIU;
               default:  w_aluOp = ALUOP_ADD;
            endcase
         end
         OP_LUI: begin
            o_loadimmed   = 1'b1;
            w_decRegWrite = 1'b1;
         end
         OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
            o_ALUSrc      = 1'b1;
            w_decRegWrite = 1'b1;
            w_isLoad      = 1'b1;
            case (w_opcode)
               OP_LW:   o_memtoreg = 1'b1;
               OP_LHU:  o_ExtendOp = 3'b100;
               OP_LH:   o_ExtendOp = 3'b101;
               OP_LBU:  o_ExtendOp = 3'b110;
               default: o_ExtendOp = 3'b111;
            endcase
         end
         OP_SW: begin
            o_ALUSrc  = 1'b1;
            w_isStore = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_aluCtrl = ALU_ADD;
      case (w_aluOp)
         ALUOP_SUB:   w_aluCtrl = ALU_SUB;
         ALUOP_ANDI:  w_aluCtrl = ALU_ANDZ;
         ALUOP_ORI:   w_aluCtrl = ALU_ORZ;
         ALUOP_XORI:  w_aluCtrl = ALU_XORZ;
         ALUOP_SLTI:  w_aluCtrl = ALU_SLT;
         ALUOP_SLTIU: w_aluCtrl = ALU_SLTU;
         ALUOP_BNE:   w_aluCtrl = ALU_BNE;
         ALUOP_BLEZ:  w_aluCtrl = ALU_BLEZ;
         ALUOP_BGTZ:  w_aluCtrl = ALU_BGTZ;
         ALUOP_REGIMM: begin
            case (w_rt)
               RT_BLTZ, RT_BLTZAL: w_aluCtrl = ALU_BLTZ;
               RT_BGEZ, RT_BGEZAL: w_aluCtrl = ALU_BGEZ;
               default:            w_aluCtrl = ALU_ADD;
            endcase
         end
         ALUOP_RTYPE: begin
            case (w_funct)
               FN_ADDU: w_aluCtrl = ALU_ADD;
               FN_SUBU: w_aluCtrl = ALU_SUB;
               FN_AND:  w_aluCtrl = ALU_AND;
               FN_OR:   w_aluCtrl = ALU_OR;
               FN_XOR:  w_aluCtrl = ALU_XOR;
               FN_NOR:  w_aluCtrl = ALU_NOR;
               FN_SLT:  w_aluCtrl = ALU_SLT;
               FN_SLTU: w_aluCtrl = ALU_SLTU;
               FN_SLL:  w_aluCtrl = ALU_SLL;
               FN_SRL:  w_aluCtrl = ALU_SRL;
               FN_SRA:  w_aluCtrl = ALU_SRA;
               FN_SLLV: w_aluCtrl = ALU_SLLV;
               FN_SRLV: w_aluCtrl = ALU_SRLV;
               FN_SRAV: w_aluCtrl = ALU_SRAV;
               default: w_aluCtrl = ALU_ADD;
            endcase
         end
         default: w_aluCtrl = ALU_ADD;
      endcase
   end

   // Register-file and PC strobes drop during a stall; bus requests must stay asserted
   assign o_memread     = (r_state == ST_FETCH) || ((r_state == ST_EXEC1) && w_isLoad);
   assign o_memwrite    = (r_state == ST_EXEC1) && w_isStore;
   assign o_pctoadd     = (r_state == ST_FETCH);
   assign o_inwrite     = (r_state == ST_DECODE) && !i_waitrequest;
   assign o_pcwrite     = (r_state == ST_EXEC2) && !i_waitrequest;
   assign o_regwrite    = (r_state == ST_EXEC2) && w_decRegWrite && !i_waitrequest;
   assign o_div_mult_en = (r_state == ST_EXEC2) && w_decDivMult && !i_waitrequest;

   mips_alu_core u_alu (
      .i_a      (i_a),
      .i_b      (i_b),
      .i_shamt  (w_shamt),
      .i_ctrl   (w_aluCtrl),
      .o_result (o_result),
      .o_zero   (o_zero)
   );

endmodule

// File: tb/tb_mips_ctrl_exec.sv
// Directed self-checking bench for mips_ctrl_exec: sequencing, stalls, halt, decode and ALU.
module tb_mips_ctrl_exec;

   logic        i_clk = 1'b0;
   logic        i_reset, i_waitrequest, i_pc_zero;
   logic [31:0] i_instr, i_a, i_b;
   logic [3:0]  o_state;
   logic        o_active, o_memread, o_memwrite, o_pctoadd, o_inwrite, o_pcwrite, o_regwrite;
   logic        o_ALUSrc, o_regdst, o_memtoreg, o_jump, o_branch, o_regtojump, o_link;
   logic        o_loadimmed, o_hitoreg, o_lotoreg, o_div_mult_en, o_div_mult_signed;
   logic [1:0]  o_div_mult_op;
   logic [2:0]  o_ExtendOp;
   logic [31:0] o_result;
   logic        o_zero;

   int assertCount = 0;
   int failCount   = 0;

   always #5 i_clk = ~i_clk;

   mips_ctrl_exec dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_waitrequest(i_waitrequest), .i_pc_zero(i_pc_zero),
      .i_instr(i_instr), .i_a(i_a), .i_b(i_b),
      .o_state(o_state), .o_active(o_active), .o_memread(o_memread), .o_memwrite(o_memwrite),
      .o_pctoadd(o_pctoadd), .o_inwrite(o_inwrite), .o_pcwrite(o_pcwrite), .o_regwrite(o_regwrite),
      .o_ALUSrc(o_ALUSrc), .o_regdst(o_regdst), .o_memtoreg(o_memtoreg), .o_jump(o_jump),
      .o_branch(o_branch), .o_regtojump(o_regtojump), .o_link(o_link), .o_loadimmed(o_loadimmed),
      .o_hitoreg(o_hitoreg), .o_lotoreg(o_lotoreg), .o_div_mult_en(o_div_mult_en),
      .o_div_mult_signed(o_div_mult_signed), .o_div_mult_op(o_div_mult_op),
      .o_ExtendOp(o_ExtendOp), .o_result(o_result), .o_zero(o_zero)
   );

   // Single comparison point: every check in the bench is counted here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
      i_instr = instr;
      i_a     = a;
      i_b     = b;
      #1;
   endtask

   task automatic gotoState(input logic [3:0] target);
      for (int i = 0; i < 8 && o_state != target; i++) tick();
      checkOutput("reachState", 32'(o_state), 32'(target));
   endtask

   function automatic logic [31:0] rType(input logic [5:0] funct, input logic [4:0] shamt);
      return {6'h00, 5'd0, 5'd0, 5'd0, shamt, funct};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rt);
      return {op, 5'd0, rt, 16'h0000};
   endfunction

   int expSeq[6] = '{1, 2, 3, 4, 1, 2};

   initial begin
      i_reset = 1'b1; i_waitrequest = 1'b0; i_pc_zero = 1'b0;
      i_instr = 32'd0; i_a = 32'd0; i_b = 32'd0;
      tick(); tick();
      i_reset = 1'b0;
      #1;
      checkOutput("resetState", 32'(o_state), 32'd0);
      checkOutput("resetActive", 32'(o_active), 32'd0);

      applyStimulus(rType(6'h21, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("adduResult", o_result, 32'h0000_0000);
      checkOutput("adduZero", 32'(o_zero), 32'd1);
      checkOutput("adduRegdst", 32'(o_regdst), 32'd1);
      checkOutput("adduRegwriteHalt", 32'(o_regwrite), 32'd0);

      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("seqState", 32'(o_state), 32'(expSeq[i]));
         checkOutput("seqActive", 32'(o_active), 32'd1);
      end

      checkOutput("decodeInwrite", 32'(o_inwrite), 32'd1);
      i_waitrequest = 1'b1;
      #1;
      checkOutput("stallInwrite", 32'(o_inwrite), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stallState", 32'(o_state), 32'd2);
         checkOutput("stallActive", 32'(o_active), 32'd1);
      end
      i_waitrequest = 1'b0;
      tick();
      checkOutput("exec1State", 32'(o_state), 32'd3);
      checkOutput("adduRegwriteExec1", 32'(o_regwrite), 32'd0);
      tick();
      checkOutput("exec2State", 32'(o_state), 32'd4);
      checkOutput("adduRegwriteExec2", 32'(o_regwrite), 32'd1);
      checkOutput("exec2Pcwrite", 32'(o_pcwrite), 32'd1);
      i_waitrequest = 1'b1;
      #1;
      checkOutput("stallRegwrite", 32'(o_regwrite), 32'd0);
      checkOutput("stallPcwrite", 32'(o_pcwrite), 32'd0);
      tick();
      checkOutput("stallExec2State", 32'(o_state), 32'd4);
      i_waitrequest = 1'b0;
      tick();
      checkOutput("wrapFetch", 32'(o_state), 32'd1);
      checkOutput("fetchMemread", 32'(o_memread), 32'd1);
      checkOutput("fetchPctoadd", 32'(o_pctoadd), 32'd1);
      checkOutput("fetchRegwrite", 32'(o_regwrite), 32'd0);

      gotoState(4'd3);
      i_pc_zero = 1'b1;
      tick();
      checkOutput("haltState", 32'(o_state), 32'd0);
      checkOutput("haltActive", 32'(o_active), 32'd0);
      i_pc_zero = 1'b0;
      tick();
      checkOutput("restartState", 32'(o_state), 32'd1);
      checkOutput("restartActive", 32'(o_active), 32'd1);

      applyStimulus(rType(6'h03, 5'd4), 32'd0, 32'h8000_0000);
      checkOutput("sraResult", o_result, 32'hF800_0000);
      applyStimulus(rType(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("sltResult", o_result, 32'd1);
      applyStimulus(rType(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("sltuResult", o_result, 32'd0);
      applyStimulus(iType(6'h0D, 5'd0), 32'd0, 32'hFFFF_8001);
      checkOutput("oriResult", o_result, 32'h0000_8001);
      checkOutput("oriALUSrc", 32'(o_ALUSrc), 32'd1);
      applyStimulus(iType(6'h05, 5'd0), 32'd5, 32'd5);
      checkOutput("bneEqualZero", 32'(o_zero), 32'd0);
      checkOutput("bneBranch", 32'(o_branch), 32'd1);
      applyStimulus(iType(6'h05, 5'd0), 32'd5, 32'd6);
      checkOutput("bneDiffZero", 32'(o_zero), 32'd1);
      applyStimulus(iType(6'h06, 5'd0), 32'd1, 32'd0);
      checkOutput("blezPosZero", 32'(o_zero), 32'd0);

      applyStimulus(iType(6'h01, 5'h11), 32'd0, 32'd0);
      checkOutput("bgezalZero", 32'(o_zero), 32'd1);
      checkOutput("bgezalLink", 32'(o_link), 32'd1);
      gotoState(4'd4);
      checkOutput("bgezalRegwrite", 32'(o_regwrite), 32'd1);

      applyStimulus(iType(6'h20, 5'd0), 32'd0, 32'd0);
      checkOutput("lbExtendOp", 32'(o_ExtendOp), 32'd7);
      gotoState(4'd1);
      checkOutput("lbMemreadFetch", 32'(o_memread), 32'd1);
      tick();
      checkOutput("lbMemreadDecode", 32'(o_memread), 32'd0);
      tick();
      checkOutput("lbMemreadExec1", 32'(o_memread), 32'd1);
      tick();
      checkOutput("lbMemreadExec2", 32'(o_memread), 32'd0);

      applyStimulus(iType(6'h2B, 5'd0), 32'd0, 32'd0);
      gotoState(4'd1);
      checkOutput("swMemwriteFetch", 32'(o_memwrite), 32'd0);
      tick(); tick();
      checkOutput("swMemwriteExec1", 32'(o_memwrite), 32'd1);
      tick();
      checkOutput("swMemwriteExec2", 32'(o_memwrite), 32'd0);
      checkOutput("swRegwrite", 32'(o_regwrite), 32'd0);

      applyStimulus(rType(6'h1B, 5'd0), 32'd0, 32'd0);
      gotoState(4'd4);
      checkOutput("divuEn", 32'(o_div_mult_en), 32'd1);
      checkOutput("divuSigned", 32'(o_div_mult_signed), 32'd0);
      checkOutput("divuOp", 32'(o_div_mult_op), 32'd1);
      checkOutput("divuRegwrite", 32'(o_regwrite), 32'd0);

      applyStimulus(rType(6'h09, 5'd0), 32'd0, 32'd0);
      checkOutput("jalrJump", 32'(o_jump), 32'd1);
      checkOutput("jalrRegtojump", 32'(o_regtojump), 32'd1);
      checkOutput("jalrLink", 32'(o_link), 32'd1);
      checkOutput("jalrRegdst", 32'(o_regdst), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mips_ctrl_exec.md
Name: mips_ctrl_exec

Overview:
- Combined sequencer, main decoder, ALU-control decoder and 32-bit ALU for the multi-cycle MIPS-I bus CPU.
- Drives every datapath strobe from the current state and instruction, and produces the ALU result and the zero/branch-taken flag.
- Sits between the instruction register and register file (operands in) and the PC/memory/writeback muxes (controls out).

Parameters:
- none (fixed 32-bit MIPS-I)

Ports:
- clk in 1: rising-edge clock
- reset in 1: synchronous, active-high
- waitrequest in 1: Avalon stall; high freezes state and write strobes
- pc_zero in 1: PC equals 0x00000000 (halt request)
- instr in 32: current instruction (opcode [31:26], rt [20:16], shamt [10:6], funct [5:0])
- a in 32: rs operand
- b in 32: second operand (rt or sign-extended immediate, already muxed by ALUSrc)
- state out 4: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2
- active out 1: CPU running
- memread, memwrite, pctoadd, inwrite, pcwrite, regwrite out 1 each: bus/register strobes
- ALUSrc, regdst, memtoreg, jump, branch, regtojump, link, loadimmed, hitoreg, lotoreg out 1 each: datapath selects
- div_mult_en, div_mult_signed out 1 each; div_mult_op out 2: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- ExtendOp out 3: 000 none, 100 LHU, 101 LH, 110 LBU, 111 LB
- result out 32: ALU result
- zero out 1: result == 0

Behaviour:
- Reset: state=0, active=0.
- Sequencer advances only when waitrequest=0.
  - HALT→FETCH sets active=1.
  - FETCH→DECODE→EXEC1→EXEC2→FETCH.
- pc_zero=1 in any state ≠ HALT: next state HALT, active=0. This overrides the sequencer.
- Strobes by state; any opcode not listed below is a NOP.
  - FETCH: memread=1, pctoadd=1.
  - DECODE: inwrite=1.
  - EXEC1: memread=1 for loads; memwrite=1 for SW.
  - EXEC2: pcwrite=1; regwrite and div_mult_en per instruction.
- inwrite, pcwrite, regwrite and div_mult_en are gated off while waitrequest=1. memread and memwrite hold.
- All select outputs are a pure function of instr, valid in every state.
- Per-instruction decode:
  - R-ALU (ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV): regdst=1, regwrite.
  - ADDIU ANDI ORI XORI SLTI SLTIU: ALUSrc=1, regwrite.
  - LUI: loadimmed, regwrite.
  - LW: ALUSrc, memtoreg, regwrite. LB/LBU/LH/LHU: ALUSrc, the ExtendOp code above, regwrite.
  - SW: ALUSrc.
  - BEQ BNE BLEZ BGTZ BLTZ BGEZ: branch. BLTZAL/BGEZAL additionally set link and regwrite (unconditional).
  - J: jump. JAL: jump, link, regwrite.
  - JR: jump, regtojump. JALR: jump, regtojump, link, regdst=1, regwrite.
  - MFHI/MFLO: hitoreg/lotoreg, regdst=1, regwrite.
  - MULT/MULTU/DIV/DIVU/MTHI/MTLO: div_mult_en. div_mult_signed=1 for MULT/DIV.
- Main decoder emits a 4-bit ALUOp:
  - ADD: memory, ADDIU
  - SUB: BEQ
  - RTYPE: decode funct
  - ANDI, ORI, XORI, SLTI, SLTIU, BNE, BLEZ, BGTZ
  - REGIMM: decode rt; 00000/10000 → BLTZ, 00001/10001 → BGEZ
- ALU-control maps ALUOp+funct+rt to a 5-bit ALUCtrl. Unknown combinations select ADD.
- ALU functions; all arithmetic wraps mod 2^32, no overflow traps:
  - ADD, SUB, AND, OR, XOR, NOR.
  - SLT signed, SLTU unsigned; result 1/0.
  - SLL/SRL/SRA shift b by shamt. SLLV/SRLV/SRAV shift b by a[4:0].
  - ANDZ/ORZ/XORZ: a op {16'h0, b[15:0]} (zero-extended immediate).
- Branch ops give result=0 exactly when the branch is taken, so zero=taken:
  - BEQ uses SUB.
  - BNE: 0 if a≠b.
  - BLEZ: 0 if signed a≤0. BGTZ: 0 if a>0. BLTZ: 0 if a<0. BGEZ: 0 if a≥0.

Decomposition:
- Package mips_pkg holds state enum, ALUOp codes, ALUCtrl codes, opcode/funct/REGIMM constants.
- Natural sub-module: mips_alu_core (pure combinational ALU). Decoders and sequencer stay in the top.

Test Plan:
- Reset, then waitrequest=0 for 6 clocks → state 0,1,2,3,4,1,2; active=1 from first edge. waitrequest=1 for 3 clocks → state and active frozen, pcwrite/regwrite=0.
- pc_zero=1 during EXEC1 → next state 0, active=0.
- instr=ADDU, a=0xFFFFFFFF, b=1 → result 0, zero=1, regdst=1, regwrite=1 only in EXEC2. SRA shamt=4 on b=0x80000000 → 0xF8000000.
- SLT a=0xFFFFFFFF, b=1 → 1; SLTU same operands → 0. ORI a=0, b=0xFFFF8001 → 0x00008001.
- BNE a=5,b=5 → zero=0; a=5,b=6 → zero=1. BGEZAL a=0 → zero=1, link=1, regwrite=1 in EXEC2. BLEZ a=1 → zero=0.
- LB: ExtendOp=111, memread=1 in FETCH and EXEC1 only. SW: memwrite=1 only in EXEC1. DIVU: div_mult_en=1, signed=0, op=01. JALR: jump, regtojump, link, regdst=1.
